mem_unit_v2: RTL and testbench
==============================

Name: mem_unit_v2

Overview:
- Parametrised successor to the single-port core memory: a byte-addressed memory with two requestor ports, instruction fetch (IF) and data (D), and a valid/grant handshake.
- Provides a programmable access latency, byte/half/word loads and stores with sign or zero extension, and misalignment detection.
- Sits between the multicycle controller/datapath and storage. Replaces the old MEMADDR/MEMDATA mux pair feeding the memory.

Parameters:
- DATA_WIDTH, 32: word width in bits. Fixed at 32 for RV32; other values are illegal.
- ADDR_WIDTH, 12: byte-address bits used. Depth is 2^ADDR_WIDTH bytes, i.e. 2^(ADDR_WIDTH-2) words.
- LATENCY, 2: cycles from accept to response. Legal range 1..8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- d_wdata  in  32  store data, right-aligned (lane 0)
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  32  extended load data; 0 for stores and on error
- d_err  out  1  one-cycle pulse alongside d_rvalid: misaligned or reserved size
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- IDLE: if d_req, accept D; else if if_req, accept IF. D has fixed priority. On accept:
  - latch port, address, we, size, unsigned, wdata;
  - pulse the matching *_gnt in the same cycle;
  - load counter with LATENCY-1;
  - go to RESP if LATENCY=1, else WAIT.
- WAIT: decrement counter each cycle; go to RESP when counter reaches 1.
- RESP: assert the selected port's rvalid, and err if applicable, for exactly one cycle, then return to IDLE.
  - No accept occurs in RESP or WAIT. Requests are simply held by the requester.
  - Accept in cycle t gives rvalid in cycle t+LATENCY. Next accept is earliest at t+LATENCY+1.
- Address handling: only addr[ADDR_WIDTH-1:0] is used; upper bits are ignored, so addresses wrap modulo depth. Word index is addr[ADDR_WIDTH-1:2], lane is addr[1:0].
- Loads:
  - Word read is combinational from the latched address in RESP.
  - Byte: select lane addr[1:0], then extend bit 7.
  - Half: select lane addr[1], then extend bit 15.
  - d_unsigned=1 zero-extends; d_unsigned=0 sign-extends.
- Stores: committed on the RESP clock edge only.
  - Byte-lane enables: byte writes 1 lane, half writes 2, word writes 4.
  - wdata is replicated onto lanes. Untouched lanes keep their contents.
- Fetch: always word, unsigned. Misaligned fetch (addr[1:0]!=0) sets no error output; the fetched word is that of addr with [1:0] forced to 00.
- Errors on D:
  - half with addr[0]=1, word with addr[1:0]!=0, or size=11 gives d_err=1 with d_rvalid.
  - d_rdata=0 and no memory write.
- Reset:
  - All outputs go to 0, FSM to IDLE, counter to 0, latched request cleared.
  - Memory contents are unaffected.
  - Reset during WAIT or RESP aborts the access: no rvalid, store not committed.
- Simultaneous d_req and if_req in IDLE: D wins. IF stays pending and is accepted at the next IDLE.
- Outputs are registered or decoded from state. No combinational path from req inputs to rvalid. gnt is combinational from req and state IDLE.

Test Plan:
- LATENCY=2. Store word 0xDEADBEEF at 0x10, then load word 0x10 → d_gnt in accept cycle t; d_rvalid at t+2; d_rdata=0xDEADBEEF; d_err=0.
- Load byte 0x13 signed → 0xFFFFFFDE. Load byte 0x13 unsigned → 0x000000DE. Load half 0x12 signed → 0xFFFFDEAD.
- Store byte 0x55 at 0x11 over 0xDEADBEEF, then load word 0x10 → 0xDEAD55EF.
- d_req and if_req both high in IDLE → d_gnt at t, d_rvalid at t+2. if_gnt at t+3, if_rvalid at t+5. busy high t..t+2 and t+3..t+5.
- Load word at 0x12 and store half at 0x11 → d_err=1, d_rdata=0, memory unchanged. size=11 → d_err=1.
- Store word 0x12345678 to 0x20, rst asserted during WAIT → no d_rvalid, busy=0 the next cycle; later load of 0x20 returns the prior value. Also with LATENCY=1, addr 0x1010 aliases 0x0010 (ADDR_WIDTH=12).

Source files
------------

// File: rtl/mem_unit_v2.sv
// mem_unit_v2: byte-addressed memory shared by an instruction-fetch (IF) port and a data (D) port.
// Each port uses a req/gnt handshake. One access is in flight at a time, and D has fixed priority.
// An access completes LATENCY cycles after it is accepted.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), synchronous active-high reset
//   i_if_req, i_if_addr           fetch request / byte address (word fetched, low bits ignored)
//   o_if_gnt, o_if_rvalid         accept pulse, response pulse
//   o_if_rdata                    fetched word
//   i_d_req, i_d_we, i_d_addr     data request, 1 = store, byte address
//   i_d_size, i_d_unsigned        00 byte / 01 half / 10 word / 11 reserved, zero-extend loads
//   i_d_wdata                     right-aligned store data
//   o_d_gnt, o_d_rvalid, o_d_err  accept pulse, response pulse, misaligned/reserved error
//   o_d_rdata                     extended load data (0 for stores and errors)
//   o_busy                        access in progress (includes the accept cycle)
module mem_unit_v2 #(
   parameter int unsigned DATA_WIDTH = 32,  // only 32 is supported
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned LATENCY    = 2    // 1..8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_if_req,
   input  logic [31:0]           i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [DATA_WIDTH-1:0] o_if_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [31:0]           i_d_addr,
   input  logic [1:0]            i_d_size,
   input  logic                  i_d_unsigned,
   input  logic [DATA_WIDTH-1:0] i_d_wdata,
   output logic                  o_d_gnt,
   output logic                  o_d_rvalid,
   output logic [DATA_WIDTH-1:0] o_d_rdata,
   output logic                  o_d_err,
   output logic                  o_busy
);

   localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                  r_state, w_state_next;
   logic [3:0]              r_cnt, w_cnt_next;
   logic                    r_port_d, r_we, r_uns;
   logic [1:0]              r_size;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH-1:0]   r_mem [Words];

   logic                    w_acc_d, w_acc_if, w_resp, w_err, w_wr_en;
   logic [DATA_WIDTH-1:0]   w_word, w_load, w_wrep;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [3:0]              w_be;
   logic                    w_unused;

   // Address bits above the memory depth are ignored, so addresses alias modulo the depth.
   assign w_unused = ^{i_if_addr[31:ADDR_WIDTH], i_d_addr[31:ADDR_WIDTH]};

   assign w_acc_d  = (r_state == StIdle) && i_d_req;
   assign w_acc_if = (r_state == StIdle) && !i_d_req && i_if_req;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         StIdle: begin
            if (w_acc_d || w_acc_if) begin
               w_cnt_next   = 4'(LATENCY - 1);
               w_state_next = (LATENCY == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) w_state_next = StResp;
         end
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_cnt    <= 4'd0;
         r_port_d <= 1'b0;
         r_we     <= 1'b0;
         r_uns    <= 1'b0;
         r_size   <= 2'b00;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_acc_d || w_acc_if) begin
            r_port_d <= w_acc_d;
            r_we     <= w_acc_d && i_d_we;
            r_uns    <= w_acc_d ? i_d_unsigned : 1'b1;
            // Fetches are always treated as unsigned word accesses.
            r_size   <= w_acc_d ? i_d_size : 2'b10;
            r_addr   <= w_acc_d ? i_d_addr[ADDR_WIDTH-1:0] : i_if_addr[ADDR_WIDTH-1:0];
            r_wdata  <= i_d_wdata;
         end
      end
   end

   // Response decode from the latched request.
   assign w_word = r_mem[r_addr[ADDR_WIDTH-1:2]];
   assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

   assign w_err = r_port_d && ((r_size == 2'b11) ||
                               ((r_size == 2'b01) && r_addr[0]) ||
                               ((r_size == 2'b10) && (r_addr[1:0] != 2'b00)));

   always_comb begin
      w_load = w_word;
      w_be   = 4'b1111;
      w_wrep = r_wdata;
      case (r_size)
         2'b00: begin
            w_load = {{24{!r_uns && w_byte[7]}}, w_byte};
            w_be   = 4'b0001 << r_addr[1:0];
            w_wrep = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_load = {{16{!r_uns && w_half[15]}}, w_half};
            w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Gating with i_rst keeps every output low while reset is applied and aborts an access
   // that is reset in its response cycle.
   assign w_resp  = (r_state == StResp) && !i_rst;
   assign w_wr_en = w_resp && r_port_d && r_we && !w_err;

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[r_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= w_wrep[8*i +: 8];
         end
      end
   end

   assign o_d_gnt     = w_acc_d && !i_rst;
   assign o_if_gnt    = w_acc_if && !i_rst;
   assign o_d_rvalid  = w_resp && r_port_d;
   assign o_d_err     = w_resp && w_err;
   assign o_d_rdata   = (o_d_rvalid && !r_we && !w_err) ? w_load : '0;
   assign o_if_rvalid = w_resp && !r_port_d;
   assign o_if_rdata  = o_if_rvalid ? w_word : '0;
   // Busy covers the accept cycle as well as WAIT/RESP.
   assign o_busy      = !i_rst && ((r_state != StIdle) || w_acc_d || w_acc_if);

endmodule

// File: tb/tb_mem_unit_v2.sv
// Bench for mem_unit_v2: unit 0 built with LATENCY=2, unit 1 with LATENCY=1.
// A byte-array reference model predicts each response at accept time.
// A monitor compares the responses as they appear.
module tb_mem_unit_v2;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      bit          err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req [2];
   logic [31:0] if_addr [2];
   logic        if_gnt [2];
   logic        if_rvalid [2];
   logic [31:0] if_rdata [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [31:0] d_addr [2];
   logic [1:0]  d_size [2];
   logic        d_unsigned [2];
   logic [31:0] d_wdata [2];
   logic        d_gnt [2];
   logic        d_rvalid [2];
   logic [31:0] d_rdata [2];
   logic        d_err [2];
   logic        busy [2];

   logic [7:0]  ref_mem [2][4096];
   exp_t        sb0 [$];
   exp_t        sb1 [$];
   int          cyc = 0;
   int          free_c [2];
   int          last_acc [2];
   bit          mon_en = 1'b0;
   int          nvec = 0;
   int          nerr = 0;
   int          acc_d, acc_i, acc_x;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_unit_v2 #(
         .DATA_WIDTH (32),
         .ADDR_WIDTH (12),
         .LATENCY    ((g == 0) ? 2 : 1)
      ) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_if_req     (if_req[g]),
         .i_if_addr    (if_addr[g]),
         .o_if_gnt     (if_gnt[g]),
         .o_if_rvalid  (if_rvalid[g]),
         .o_if_rdata   (if_rdata[g]),
         .i_d_req      (d_req[g]),
         .i_d_we       (d_we[g]),
         .i_d_addr     (d_addr[g]),
         .i_d_size     (d_size[g]),
         .i_d_unsigned (d_unsigned[g]),
         .i_d_wdata    (d_wdata[g]),
         .o_d_gnt      (d_gnt[g]),
         .o_d_rvalid   (d_rvalid[g]),
         .o_d_rdata    (d_rdata[g]),
         .o_d_err      (d_err[g]),
         .o_busy       (busy[g])
      );
   end

   function automatic int lat(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain byte array, little-endian, addresses modulo 4096.
   task automatic model(input int u, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                        output exp_t e);
      int          a, n;
      logic [31:0] v;
      a = int'(addr & 32'h0000_0FFF);
      e.is_d = is_d;
      e.err  = 1'b0;
      e.data = 32'h0;
      if (!is_d) begin
         a = a & ~3;
         for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_mem[u][a+i];
      end else begin
         n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
         e.err = (size == 2'd3) || (a % n != 0);
         if (!e.err) begin
            if (we) begin
               for (int i = 0; i < n; i++) ref_mem[u][a+i] = wdata[8*i +: 8];
            end else begin
               v = 32'h0;
               for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[u][a+i];
               if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
               e.data = v;
            end
         end
      end
   endtask

   task automatic push(input int u, input exp_t e);
      if (u == 0) sb0.push_back(e);
      else sb1.push_back(e);
   endtask

   // Raise a request, wait for its grant and check the accept cycle.
   // With abort set, reset is pulsed in the cycle after the accept.
   task automatic issue(input int u, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                        input bit abort, output int acc);
      int   start;
      bit   got;
      exp_t e;
      @(posedge clk); #1;
      start = cyc;
      acc = -1;
      if (is_d) begin
         d_we[u] = we; d_addr[u] = addr; d_size[u] = size;
         d_unsigned[u] = uns; d_wdata[u] = wdata; d_req[u] = 1'b1;
      end else begin
         if_addr[u] = addr; if_req[u] = 1'b1;
      end
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         @(negedge clk);
         got = is_d ? d_gnt[u] : if_gnt[u];
      end
      if (!got) begin
         nvec++; nerr++;
         $display("FAIL gnt_timeout: unit %0d port_d=%0d got no grant, want grant within 40 cycles",
                  u, is_d);
      end else begin
         acc = cyc;
         chk(is_d ? "d_gnt_cycle" : "if_gnt_cycle", 32'(cyc),
             32'((start > free_c[u]) ? start : free_c[u]));
         free_c[u]   = cyc + lat(u) + 1;
         last_acc[u] = cyc;
         if (!abort) begin
            model(u, is_d, we, addr, size, uns, wdata, e);
            e.cyc = cyc + lat(u);
            push(u, e);
         end
      end
      @(posedge clk); #1;
      if (is_d) d_req[u] = 1'b0;
      else if_req[u] = 1'b0;
      if (abort && got) begin
         rst = 1'b1;
         last_acc[u] = -100;
         free_c[u] = cyc + 1;
         @(posedge clk); #1;
         rst = 1'b0;
      end
   endtask

   task automatic mon_unit(input int u);
      exp_t e;
      bit   have;
      int   la;
      la = last_acc[u];
      chk($sformatf("busy_u%0d", u), 32'(busy[u]),
          32'(!rst && cyc >= la && cyc <= la + lat(u)));
      chk($sformatf("gnt_excl_u%0d", u), 32'(d_gnt[u] & if_gnt[u]), 32'h0);
      have = (u == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
      if (d_rvalid[u] || if_rvalid[u]) begin
         if (!have) begin
            nvec++; nerr++;
            $display("FAIL spurious_rvalid_u%0d: got rvalid at cycle %0d, want none", u, cyc);
         end else begin
            e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("rvalid_port_u%0d", u), {30'h0, d_rvalid[u], if_rvalid[u]},
                e.is_d ? 32'h2 : 32'h1);
            chk($sformatf("rdata_u%0d", u), e.is_d ? d_rdata[u] : if_rdata[u], e.data);
            chk($sformatf("d_err_u%0d", u), 32'(d_err[u]), 32'(e.err));
            chk($sformatf("rvalid_cycle_u%0d", u), 32'(cyc), 32'(e.cyc));
         end
      end else begin
         chk($sformatf("err_no_rvalid_u%0d", u), 32'(d_err[u]), 32'h0);
         if (have) begin
            e = (u == 0) ? sb0[0] : sb1[0];
            if (e.cyc <= cyc) begin
               nvec++; nerr++;
               $display("FAIL missing_rvalid_u%0d: got no rvalid at cycle %0d, want one", u, cyc);
               if (u == 0) void'(sb0.pop_front());
               else void'(sb1.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         for (int u = 0; u < 2; u++) mon_unit(u);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, want finish before 2 ms");
      $fatal(1);
   end

   initial begin
      int          u;
      bit          is_d, we, uns;
      logic [31:0] addr, wdata;
      logic [1:0]  size;

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b0; if_addr[k] = 32'h0; d_req[k] = 1'b0; d_we[k] = 1'b0;
         d_addr[k] = 32'h0; d_size[k] = 2'd0; d_unsigned[k] = 1'b0; d_wdata[k] = 32'h0;
         last_acc[k] = -100; free_c[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      d_req[0] = 1'b1;   // requests during reset must not be granted
      if_req[1] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_d_gnt", 32'(d_gnt[k]), 32'h0);
         chk("rst_if_gnt", 32'(if_gnt[k]), 32'h0);
         chk("rst_rvalid", {30'h0, d_rvalid[k], if_rvalid[k]}, 32'h0);
         chk("rst_rdata", d_rdata[k] | if_rdata[k], 32'h0);
         chk("rst_err_busy", {30'h0, d_err[k], busy[k]}, 32'h0);
      end
      @(posedge clk); #1;
      d_req[0] = 1'b0; if_req[1] = 1'b0;
      rst = 1'b0;
      free_c[0] = cyc; free_c[1] = cyc;
      mon_en = 1'b1;

      // Known contents for the first 256 bytes of both units.
      for (int i = 0; i < 64; i++) begin
         issue(0, 1, 1, 32'(4*i), 2'd2, 0, $urandom, 0, acc_x);
         issue(1, 1, 1, 32'(4*i), 2'd2, 0, $urandom, 0, acc_x);
      end

      // Word store/load and sign/zero extension.
      issue(0, 1, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 0, acc_x);
      issue(0, 1, 0, 32'h10, 2'd2, 0, 32'h0, 0, acc_x);
      issue(0, 1, 0, 32'h13, 2'd0, 0, 32'h0, 0, acc_x);
      issue(0, 1, 0, 32'h13, 2'd0, 1, 32'h0, 0, acc_x);
      issue(0, 1, 0, 32'h12, 2'd1, 0, 32'h0, 0, acc_x);
      issue(0, 1, 0, 32'h10, 2'd1, 1, 32'h0, 0, acc_x);
      // Byte store merges into the existing word.
      issue(0, 1, 1, 32'h11, 2'd0, 0, 32'hFFFF_FF55, 0, acc_x);
      issue(0, 1, 0, 32'h10, 2'd2, 0, 32'h0, 0, acc_x);

      // Simultaneous requests: D first, IF accepted at the next idle cycle.
      fork
         issue(0, 1, 0, 32'h10, 2'd2, 0, 32'h0, 0, acc_d);
         issue(0, 0, 0, 32'h10, 2'd2, 0, 32'h0, 0, acc_i);
      join
      chk("if_after_d_accept", 32'(acc_i), 32'(acc_d + 3));

      // Error cases leave memory unchanged.
      issue(0, 1, 0, 32'h12, 2'd2, 0, 32'h0, 0, acc_x);
      issue(0, 1, 1, 32'h11, 2'd1, 0, 32'h0000_1234, 0, acc_x);
      issue(0, 1, 0, 32'h10, 2'd3, 0, 32'h0, 0, acc_x);
      issue(0, 1, 1, 32'h10, 2'd3, 0, 32'h0, 0, acc_x);
      issue(0, 1, 0, 32'h10, 2'd2, 0, 32'h0, 0, acc_x);

      // Store aborted by reset in WAIT, then the old value is still there.
      issue(0, 1, 1, 32'h20, 2'd2, 0, 32'h1234_5678, 1, acc_x);
      issue(0, 1, 0, 32'h20, 2'd2, 0, 32'h0, 0, acc_x);

      // LATENCY=1 unit: aliasing above ADDR_WIDTH and misaligned fetch.
      issue(1, 1, 1, 32'h0010, 2'd2, 0, 32'hA5A5_5A5A, 0, acc_x);
      issue(1, 1, 0, 32'h1010, 2'd2, 0, 32'h0, 0, acc_x);
      issue(1, 0, 0, 32'h1012, 2'd2, 0, 32'h0, 0, acc_x);
      issue(1, 1, 1, 32'hF013, 2'd0, 0, 32'h0000_0081, 0, acc_x);
      issue(1, 1, 0, 32'h0013, 2'd0, 0, 32'h0, 0, acc_x);

      // Randomized traffic over the initialised region, with random upper address bits.
      for (int n = 0; n < 300; n++) begin
         u     = int'($urandom_range(0, 1));
         is_d  = ($urandom_range(0, 3) != 0);
         we    = $urandom_range(0, 1) != 0;
         uns   = $urandom_range(0, 1) != 0;
         size  = 2'($urandom_range(0, 3));
         addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
         wdata = $urandom;
         issue(u, is_d, we, addr, size, uns, wdata, 0, acc_x);
      end

      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("sb_drain_u0", 32'(sb0.size()), 32'h0);
      chk("sb_drain_u1", 32'(sb1.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
